wb_slave_regfile: RTL and testbench
===================================

Name: wb_slave_regfile

Overview:
- Wishbone classic-cycle slave that sits directly downstream of the team's Wishbone master.
- It consumes the master's cyc/stb/we/adr/sel/dat/tag outputs and returns ack_o, dat_o and tgd_o.
- It contains a small byte-enabled register file with a per-word data-tag store and a programmable number of wait states.
- It is the default target for master bring-up and for system-level simulation.

Parameters:
- DATA_W, 32, data bus width; must be a multiple of 8.
- ADR_W, 32, address bus width; byte-addressed.
- SEL_W, DATA_W/8, number of byte-select lines.
- TAG_W, 4, width of the tga/tgd/tgc tags.
- DEPTH_LOG2, 4, log2 of the number of words (16 words by default).
- WAIT_STATES, 1, cycles inserted between strobe capture and ack; range 0..15.
- BASE_ADR, 0, byte base address of the register file; aligned to 4*2^DEPTH_LOG2.

Ports:
- clk_i  in  1  system clock; all logic is rising-edge.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  transfer strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADR_W  byte address.
- sel_i  in  SEL_W  byte-lane enables.
- dat_i  in  DATA_W  write data.
- tga_i  in  TAG_W  address tag; captured, ignored functionally.
- tgd_i  in  TAG_W  write-data tag; stored per word.
- tgc_i  in  TAG_W  cycle tag; captured, ignored functionally.
- dat_o  out  DATA_W  read data; valid only while ack_o=1.
- tgd_o  out  TAG_W  read-data tag; valid only while ack_o=1.
- ack_o  out  1  transfer acknowledge.
- err_o  out  1  error acknowledge; present only with WB_SLAVE_ERR_EN.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - state=IDLE, wait counter=0.
  - ack_o=0, err_o=0, dat_o=0, tgd_o=0.
  - All register words and tags cleared to 0.
  - An in-flight transfer is dropped with no write and no ack.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When cyc_i&stb_i=1, capture adr/we/sel/dat/tgd into holding registers.
  - Load the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - If cyc_i=0 or stb_i=0 at any edge, abort: return to IDLE, no write, no ack.
- RESP:
  - ack_o=1 for exactly one cycle (registered output).
  - Write: on the edge entering RESP, byte lane k of word[idx] is updated only if sel_i[k]=1; tag[idx] is replaced by tgd_i whenever any sel bit is set.
  - Read: dat_o=word[idx], tgd_o=tag[idx]. Bytes are not masked by sel.
  - Next state is always IDLE. A strobe still high in the IDLE cycle that follows starts a new transfer.
- Latency:
  - Read/write ack is asserted WAIT_STATES+1 cycles after the first edge sampling cyc_i&stb_i.
  - Minimum spacing between acks is WAIT_STATES+2 cycles.
- Outside RESP: dat_o=0, tgd_o=0, ack_o=0.
- Word index: idx=adr_i[DEPTH_LOG2+1:2]. adr_i[1:0] is ignored.
- Without WB_SLAVE_ERR_EN, upper address bits are ignored, so every address aliases into the file.
- Simultaneous events:
  - If the master deasserts cyc_i in the same cycle as RESP, the write has already been committed and ack_o is still presented.
  - Reset has priority over everything.
- Writes with sel_i=0 complete with ack_o=1 but change neither data nor tag.

Optional Feature:
- Macro: WB_SLAVE_ERR_EN.
- Enabled: err_o exists and the full address is decoded.
  - A transfer whose adr_i lies outside [BASE_ADR, BASE_ADR+4*2^DEPTH_LOG2) completes through RESP with err_o=1 and ack_o=0.
  - No write takes place, and dat_o=tgd_o=0.
  - Wait-state timing is identical to a normal transfer.
- Disabled: the err_o port is absent and aliasing applies as described under Behaviour.

Decomposition:
- Shared package wb_pkg holds:
  - default widths (DATA_W, ADR_W, TAG_W);
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - an index/range helper function.
- One sub-module, wb_slave_bytemem, holds the 2^DEPTH_LOG2 × DATA_W storage with per-byte write enable, the parallel tag array, and an async-reset clear.
- The FSM, wait counter and decode stay in wb_slave_regfile.

Test Plan:
- Write then read:
  - Stimulus: WAIT_STATES=1; write adr=0x8, dat=0xDEADBEEF, sel=4'hF, tgd=4'h5; then read adr=0x8.
  - Response: each ack comes 2 cycles after stb; the read returns dat_o=0xDEADBEEF, tgd_o=4'h5.
- Byte lanes:
  - Stimulus: word 0x4 holds 0x11223344; write dat=0xAABBCCDD with sel=4'b0101; then read.
  - Response: 0x11BB33DD.
- Abort:
  - Stimulus: WAIT_STATES=3; start a write to 0xC; drop stb_i after 1 cycle.
  - Response: no ack; a later read of 0xC returns 0x00000000.
- Back-to-back with zero wait states:
  - Stimulus: WAIT_STATES=0; hold stb high for 4 reads.
  - Response: ack pattern 1,0,1,0,…; dat_o is 0 in the non-ack cycles.
- Reset mid-transfer:
  - Stimulus: assert rst_n_i=0 during WAIT of a write to 0x0 that holds 0x1234.
  - Response: ack_o is immediately 0 (asynchronous); a read after reset returns 0.
- Range error (WB_SLAVE_ERR_EN):
  - Stimulus: BASE_ADR=0x100; read adr=0x40.
  - Response: err_o=1 for one cycle, ack_o=0, dat_o=0.
  - Stimulus: write to adr=0x104.
  - Response: ack_o=1 and word[1] is updated.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: default widths, FSM encoding,
// and the address-window helper used by the optional range check.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADR_W  = 32;
  localparam int WB_TAG_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic in_range(
    input logic [63:0] adr,
    input logic [63:0] base,
    input int unsigned depth_log2
  );
    logic [63:0] span;
    span = 64'd4 << depth_log2;
    return (adr >= base) && ((adr - base) < span);
  endfunction

endpackage

// File: rtl/wb_slave_bytemem.sv
// Word storage with per-byte write enables and a parallel tag array.
// Both arrays clear asynchronously on reset; reads are combinational.
module wb_slave_bytemem
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int SEL_W      = DATA_W / 8,
  parameter int TAG_W      = WB_TAG_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [SEL_W-1:0]      be,
  input  logic [DATA_W-1:0]     wdat,
  input  logic [TAG_W-1:0]      wtag,
  output logic [DATA_W-1:0]     rdat,
  output logic [TAG_W-1:0]      rtag
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (we) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (be[k]) mem_q[idx][8*k +: 8] <= wdat[8*k +: 8];
      end
      // an all-zero select leaves the tag alone as well
      if (|be) tag_q[idx] <= wtag;
    end
  end

  assign rdat = mem_q[idx];
  assign rtag = tag_q[idx];

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic slave register file with programmable wait states.
// Define WB_SLAVE_ERR_EN for full address decode and the err_o port.
module wb_slave_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADR_W       = WB_ADR_W,
  parameter int SEL_W       = DATA_W / 8,
  parameter int TAG_W       = WB_TAG_W,
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_STATES = 1,
  parameter logic [ADR_W-1:0] BASE_ADR = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [TAG_W-1:0]  tga_i,
  input  logic [TAG_W-1:0]  tgd_i,
  input  logic [TAG_W-1:0]  tgc_i,
  output logic [DATA_W-1:0] dat_o,
  output logic [TAG_W-1:0]  tgd_o,
`ifdef WB_SLAVE_ERR_EN
  output logic              err_o,
`endif
  output logic              ack_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       enter_resp;
  logic       strobe;

  logic [ADR_W-1:0]  adr_q;
  logic              we_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] dat_q;
  logic [TAG_W-1:0]  tgd_q;
  logic [2*TAG_W-1:0] tag_unused_q;

  logic [ADR_W-1:0]  cur_adr;
  logic              cur_we;
  logic [SEL_W-1:0]  cur_sel;
  logic [DATA_W-1:0] cur_dat;
  logic [TAG_W-1:0]  cur_tgd;
  logic              hit;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdat;
  logic [TAG_W-1:0]  mem_rtag;
  logic              err_q;
  logic              unused;

  assign strobe = cyc_i & stb_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          cnt_d = WS;
          if (WS == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!strobe) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // with zero wait states the write commits on the capture edge itself
  always_comb begin
    if (state_q == IDLE) begin
      cur_adr = adr_i;
      cur_we  = we_i;
      cur_sel = sel_i;
      cur_dat = dat_i;
      cur_tgd = tgd_i;
    end else begin
      cur_adr = adr_q;
      cur_we  = we_q;
      cur_sel = sel_q;
      cur_dat = dat_q;
      cur_tgd = tgd_q;
    end
  end

`ifdef WB_SLAVE_ERR_EN
  assign hit = in_range(64'(cur_adr), 64'(BASE_ADR), DEPTH_LOG2);
  assign err_o = err_q;
`else
  assign hit = 1'b1;
`endif

  assign mem_we = enter_resp & cur_we & hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      dat_q        <= '0;
      tgd_q        <= '0;
      tag_unused_q <= '0;
      ack_o        <= 1'b0;
      err_q        <= 1'b0;
      dat_o        <= '0;
      tgd_o        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && strobe) begin
        adr_q        <= adr_i;
        we_q         <= we_i;
        sel_q        <= sel_i;
        dat_q        <= dat_i;
        tgd_q        <= tgd_i;
        tag_unused_q <= {tga_i, tgc_i};
      end
      ack_o <= enter_resp & hit;
      err_q <= enter_resp & ~hit;
      if (enter_resp & ~cur_we & hit) begin
        dat_o <= mem_rdat;
        tgd_o <= mem_rtag;
      end else begin
        dat_o <= '0;
        tgd_o <= '0;
      end
    end
  end

  wb_slave_bytemem #(
    .DATA_W    (DATA_W),
    .SEL_W     (SEL_W),
    .TAG_W     (TAG_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk_i),
    .rst_n(rst_n_i),
    .we   (mem_we),
    .idx  (cur_adr[DEPTH_LOG2+1:2]),
    .be   (cur_sel),
    .wdat (cur_dat),
    .wtag (cur_tgd),
    .rdat (mem_rdat),
    .rtag (mem_rtag)
  );

  assign unused = ^{tag_unused_q, cur_adr, err_q};

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench: four slaves (WS=1, WS=3, WS=0, WS=1 @0x100)
// on a shared bus, each selected by its own strobe.
module tb_wb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc;
  logic        we;
  logic [3:0]  stb;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [3:0]  tga;
  logic [3:0]  tgc;
  logic [3:0]  tgd;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [31:0] rd [4];
  logic [3:0]  rt [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_slave_regfile #(
      .WAIT_STATES((g == 1) ? 3 : ((g == 2) ? 0 : 1)),
      .BASE_ADR   ((g == 3) ? 32'h100 : 32'h0)
    ) u_dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .cyc_i  (cyc),
      .stb_i  (stb[g]),
      .we_i   (we),
      .adr_i  (adr),
      .sel_i  (sel),
      .dat_i  (dat),
      .tga_i  (tga),
      .tgd_i  (tgd),
      .tgc_i  (tgc),
      .dat_o  (rd[g]),
      .tgd_o  (rt[g]),
`ifdef WB_SLAVE_ERR_EN
      .err_o  (err[g]),
`endif
      .ack_o  (ack[g])
    );
  end

`ifndef WB_SLAVE_ERR_EN
  assign err = '0;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int u, input logic w,
                      input logic [31:0] a,
                      input logic [3:0] s,
                      input logic [31:0] d,
                      input logic [3:0] t,
                      output logic [31:0] rdat,
                      output logic [3:0] rtag,
                      output int lat,
                      output logic got_ack,
                      output logic got_err);
    @(negedge clk);
    cyc = 1'b1; stb[u] = 1'b1; we = w;
    adr = a; sel = s; dat = d; tgd = t;
    lat = 0; rdat = '0; rtag = '0;
    got_ack = 1'b0; got_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack[u] || err[u]) begin
        lat = n; rdat = rd[u]; rtag = rt[u];
        got_ack = ack[u]; got_err = err[u];
        break;
      end
    end
    cyc = 1'b0; stb = '0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input string tag, input int u,
                    input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, input logic [3:0] t,
                    input int el);
    logic [31:0] rdat;
    logic [3:0]  rtag;
    int          lat;
    logic        ga, ge;
    xfer(u, 1'b1, a, s, d, t, rdat, rtag, lat, ga, ge);
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_ack"}, 64'(ga), 64'd1);
  endtask

  task automatic rdc(input string tag, input int u,
                     input logic [31:0] a,
                     input logic [31:0] ed, input logic [3:0] et,
                     input int el);
    logic [31:0] rdat;
    logic [3:0]  rtag;
    int          lat;
    logic        ga, ge;
    xfer(u, 1'b0, a, 4'hF, 32'h0, 4'h0, rdat, rtag, lat, ga, ge);
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_dat"}, 64'(rdat), 64'(ed));
    chk({tag, "_tgd"}, 64'(rtag), 64'(et));
  endtask

  initial begin
    int          acks;
    logic [31:0] rdat;
    logic [3:0]  rtag;
    int          lat;
    logic        ga, ge;

    rst_n = 1'b0; cyc = 1'b0; we = 1'b0; stb = '0;
    adr = '0; dat = '0; sel = '0;
    tga = 4'hA; tgc = 4'hC; tgd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack[0]), 64'd0);
    chk("rst_dat", 64'(rd[0]), 64'd0);
    chk("rst_tgd", 64'(rt[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    wr("wr8", 0, 32'h8, 4'hF, 32'hDEADBEEF, 4'h5, 2);
    rdc("rd8", 0, 32'h8, 32'hDEADBEEF, 4'h5, 2);

    wr("wr4", 0, 32'h4, 4'hF, 32'h11223344, 4'h1, 2);
    wr("wr4be", 0, 32'h4, 4'b0101, 32'hAABBCCDD, 4'h2, 2);
    rdc("rd4be", 0, 32'h4, 32'h11BB33DD, 4'h2, 2);

    wr("sel0", 0, 32'h8, 4'h0, 32'h0, 4'h7, 2);
    rdc("rd_sel0", 0, 32'h8, 32'hDEADBEEF, 4'h5, 2);

`ifndef WB_SLAVE_ERR_EN
    rdc("alias", 0, 32'h48, 32'hDEADBEEF, 4'h5, 2);
`endif

    wr("wr104", 3, 32'h104, 4'hF, 32'h0BADF00D, 4'h6, 2);
    rdc("rd104", 3, 32'h104, 32'h0BADF00D, 4'h6, 2);
`ifdef WB_SLAVE_ERR_EN
    xfer(3, 1'b0, 32'h40, 4'hF, 32'h0, 4'h0,
         rdat, rtag, lat, ga, ge);
    chk("err_lat", 64'(lat), 64'd2);
    chk("err_err", 64'(ge), 64'd1);
    chk("err_ack", 64'(ga), 64'd0);
    chk("err_dat", 64'(rdat), 64'd0);
`endif

    @(negedge clk);
    cyc = 1'b1; stb[1] = 1'b1; we = 1'b1;
    adr = 32'hC; sel = 4'hF; dat = 32'h55AA55AA; tgd = 4'h3;
    @(posedge clk); #1;
    chk("abort_wait", 64'(ack[1]), 64'd0);
    cyc = 1'b0; stb = '0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      acks += int'(ack[1]);
    end
    chk("abort_acks", 64'(acks), 64'd0);
    rdc("abort_rd", 1, 32'hC, 32'h0, 4'h0, 4);

    wr("b2b_wr", 2, 32'h0, 4'hF, 32'hCAFEF00D, 4'h9, 1);
    @(negedge clk);
    cyc = 1'b1; stb[2] = 1'b1; we = 1'b0;
    adr = 32'h0; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", i), 64'(ack[2]),
          (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("b2b_dat%0d", i), 64'(rd[2]),
          (i % 2 == 0) ? 64'hCAFEF00D : 64'd0);
    end
    cyc = 1'b0; stb = '0;
    @(posedge clk); #1;

    wr("pre_rst", 0, 32'h0, 4'hF, 32'h1234, 4'h4, 2);
    @(negedge clk);
    cyc = 1'b1; stb[0] = 1'b1; we = 1'b1;
    adr = 32'h0; sel = 4'hF; dat = 32'hFFFFFFFF; tgd = 4'hF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 64'(ack[0]), 64'd0);
    @(negedge clk);
    cyc = 1'b0; stb = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rdc("post_rst", 0, 32'h0, 32'h0, 4'h0, 2);

    wr("wr_async", 0, 32'h8, 4'hF, 32'h77, 4'h1, 2);
    @(negedge clk);
    cyc = 1'b1; stb[0] = 1'b1; we = 1'b0; adr = 32'h8;
    ga = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (ack[0]) begin
        ga = 1'b1;
        break;
      end
    end
    chk("async_pre_ack", 64'(ga), 64'd1);
    chk("async_pre_dat", 64'(rd[0]), 64'h77);
    rst_n = 1'b0;
    #1;
    chk("async_ack", 64'(ack[0]), 64'd0);
    chk("async_dat", 64'(rd[0]), 64'd0);
    cyc = 1'b0; stb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rdc("async_rd", 0, 32'h8, 32'h0, 4'h0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
